// File: rtl/delay_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : delay_ctrl_pkg                                               |
// | Purpose : Shared types and constants for the delay-line sequencer:     |
// |           state encoding (IDLE/FILL/RUN/FROZEN) and its width.         |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package delay_ctrl_pkg;

  localparam int ST_W = 2;

  // The encoding is visible on state_o, so the values are fixed explicitly.
  typedef enum logic [ST_W-1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    RUN    = 2'd2,
    FROZEN = 2'd3
  } state_e;

endpackage : delay_ctrl_pkg
`default_nettype wire

// File: rtl/wrap_counter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : wrap_counter                                                 |
// | Purpose : W-bit pointer counting modulo 2**W, with synchronous clear,  |
// |           parallel load and increment (priority clr > ld > inc).       |
// | Ports   : clk, rst (sync, active-high), clr, ld, ld_val[W], inc,       |
// |           cnt[W] (registered count)                                    |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module wrap_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Natural W-bit overflow provides the wrap from 2**W-1 back to 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (ld) begin
      cnt_d = ld_val;
    end else if (inc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule : wrap_counter
`default_nettype wire

// File: rtl/delay_line_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : delay_line_ctrl                                              |
// | Purpose : Sequencer for a 2-port sample RAM (registered read, 1-cycle  |
// |           latency) used as a programmable delay line, with a freeze/   |
// |           loop mode that replays the captured buffer.                  |
// | Ports   : clk, rst (sync, active-high)                                 |
// |           en, start, stop, freeze, offset[AW], sample_in[DW]           |
// |           ram_wr_en, ram_rd_en, ram_wr_addr[AW], ram_rd_addr[AW],      |
// |           ram_din[DW], ram_dout[DW] (from RAM)                         |
// |           sample_out[DW], sample_valid, state_o[2]                     |
// | Config  : FILL_MUTE_EN - when defined, reads issued during FILL still  |
// |           pulse sample_valid but sample_out is forced to 0 so stale    |
// |           RAM contents never reach the DAC path.                       |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module delay_line_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  freeze,
  input  logic [ADDR_WIDTH-1:0] offset,
  input  logic [DATA_WIDTH-1:0] sample_in,
  output logic                  ram_wr_en,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  sample_valid,
  output logic [1:0]            state_o
);

  import delay_ctrl_pkg::*;

  localparam int AW = ADDR_WIDTH;

  state_e        state_q, state_d;
  logic [AW:0]   fill_cnt_q, fill_cnt_d;
  logic          sample_valid_q, sample_valid_d;

  logic [AW:0]   eff_off;
  logic [AW:0]   fill_cnt_inc;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] frz_ptr;
  logic [AW-1:0] run_rd_addr;
  logic          wr_strobe;
  logic          rd_strobe;
  logic [AW-1:0] rd_addr;
  logic          frz_ld;
  logic          frz_inc;
  logic          out_mute;

  // offset==0 encodes a full-buffer delay of 2**AW samples.
  assign eff_off      = (offset == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, offset};
  assign fill_cnt_inc = fill_cnt_q + {{AW{1'b0}}, 1'b1};

  // (wr_ptr - eff_off) mod 2**AW == wr_ptr - offset, because eff_off and
  // offset differ only by 2**AW. The same value seeds the freeze replay.
  assign run_rd_addr = wr_ptr - offset;

  wrap_counter #(.W(AW)) u_wr_ptr (
    .clk    (clk),
    .rst    (rst),
    .clr    (1'b0),
    .ld     (1'b0),
    .ld_val ({AW{1'b0}}),
    .inc    (wr_strobe),
    .cnt    (wr_ptr)
  );

  wrap_counter #(.W(AW)) u_frz_ptr (
    .clk    (clk),
    .rst    (rst),
    .clr    (1'b0),
    .ld     (frz_ld),
    .ld_val (run_rd_addr),
    .inc    (frz_inc),
    .cnt    (frz_ptr)
  );

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    wr_strobe  = 1'b0;
    rd_strobe  = 1'b0;
    rd_addr    = '0;
    frz_ld     = 1'b0;
    frz_inc    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FILL;
          fill_cnt_d = '0;
        end
      end

      FILL: begin
        wr_strobe = en;
        rd_strobe = en;
        rd_addr   = run_rd_addr;
        if (en) begin
          fill_cnt_d = fill_cnt_inc;
          if (fill_cnt_inc == eff_off) begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        wr_strobe = en;
        rd_strobe = en;
        rd_addr   = run_rd_addr;
        if (freeze) begin
          state_d = FROZEN;
          frz_ld  = 1'b1;
        end
      end

      FROZEN: begin
        rd_strobe = en;
        rd_addr   = frz_ptr;
        frz_inc   = en;
        if (!freeze) begin
          state_d    = FILL;
          fill_cnt_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // stop has top priority over start and freeze.
    if (stop) begin
      state_d = IDLE;
    end

    sample_valid_d = rd_strobe;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      fill_cnt_q     <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      fill_cnt_q     <= fill_cnt_d;
      sample_valid_q <= sample_valid_d;
    end
  end

`ifdef FILL_MUTE_EN
  // Remember whether the read now returning was issued during FILL.
  logic rd_fill_q, rd_fill_d;

  always_comb begin
    rd_fill_d = (state_q == FILL) && rd_strobe;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_fill_q <= 1'b0;
    end else begin
      rd_fill_q <= rd_fill_d;
    end
  end

  assign out_mute = rd_fill_q;
`else
  assign out_mute = 1'b0;
`endif

  assign ram_wr_en    = wr_strobe;
  assign ram_rd_en    = rd_strobe;
  assign ram_wr_addr  = wr_ptr;
  assign ram_rd_addr  = rd_addr;
  assign ram_din      = sample_in;
  assign sample_valid = sample_valid_q;
  assign sample_out   = (sample_valid_q && !out_mute) ? ram_dout : '0;
  assign state_o      = state_q;

endmodule : delay_line_ctrl
`default_nettype wire
